// File: rtl/uart_rx_buf_if.sv
// CPU-side read/status bundle of the UART receive buffer.
// master = CPU I/O read path, slave = uart_rx_buf.
interface uart_rx_buf_if;
  logic       rd_en;
  logic       clr;
  logic [7:0] rd_data;
  logic       data_valid;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  modport master (
    output rd_en, clr,
    input  rd_data, data_valid, frame_err, overrun, parity_err
  );

  modport slave (
    input  rd_en, clr,
    output rd_data, data_valid, frame_err, overrun, parity_err
  );
endinterface

// File: rtl/uart_rx_buf.sv
// UART receiver (8N1, LSB first) feeding a first-word-fall-through byte FIFO with sticky error flags.
// Define UART_RX_PARITY_EN for 8E1 frames with even-parity checking and a live parity_err flag.
module uart_rx_buf #(
  parameter int CLOCK_HZ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx,
  uart_rx_buf_if.slave bus
);
  localparam int CLKS_PER_BIT = CLOCK_HZ / BAUD_RATE;
  localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int CNT_W        = PTR_W + 1;
  localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_IDLE
  } state_t;

  logic              rx_meta_reg, rx_sync_reg, rx_prev_reg;
  logic              rx_fall;
  state_t            state_reg, state_next;
  logic [BAUD_W-1:0] baud_reg, baud_next;
  logic [2:0]        bit_reg, bit_next;
  logic [7:0]        shift_reg, shift_next;
  logic              push;
  logic              frame_set;

  logic [7:0]        mem_reg [FIFO_DEPTH];
  logic [PTR_W-1:0]  head_reg, tail_reg;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic [FIFO_DEPTH-1:0] wr_sel;
  logic              pop, full, push_ok, overrun_set;
  logic              frame_err_reg, overrun_reg;

  // Synchroniser idles high so a reset never looks like a start edge by itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
      rx_prev_reg <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rx_sync_reg <= rx_meta_reg;
      rx_prev_reg <= rx_sync_reg;
    end
  end

  assign rx_fall = rx_prev_reg & ~rx_sync_reg;

`ifdef UART_RX_PARITY_EN
  logic par_bad_reg, par_bad_next;
  logic parity_set;
  logic parity_err_reg;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      baud_reg  <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
`ifdef UART_RX_PARITY_EN
      par_bad_reg <= par_bad_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg + 1'b1;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    push       = 1'b0;
    frame_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_next = par_bad_reg;
    parity_set   = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        baud_next = '0;
`ifdef UART_RX_PARITY_EN
        par_bad_next = 1'b0;
`endif
        if (rx_fall) state_next = START;
      end
      START: begin
        // Mid-start-bit check: a line already back high was only a glitch.
        if (baud_reg == HALF_LAST) begin
          baud_next = '0;
          bit_next  = '0;
          state_next = rx_sync_reg ? IDLE : DATA;
        end
      end
      DATA: begin
        if (baud_reg == BIT_LAST) begin
          baud_next  = '0;
          shift_next = {rx_sync_reg, shift_reg[7:1]};
          bit_next   = bit_reg + 3'd1;
          if (bit_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (baud_reg == BIT_LAST) begin
          baud_next  = '0;
          state_next = STOP;
          if (rx_sync_reg != ^shift_reg) begin
            parity_set   = 1'b1;
            par_bad_next = 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (baud_reg == BIT_LAST) begin
          baud_next = '0;
          if (rx_sync_reg) begin
            state_next = IDLE;
`ifdef UART_RX_PARITY_EN
            push = ~par_bad_reg;
`else
            push = 1'b1;
`endif
          end else begin
            frame_set  = 1'b1;
            state_next = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        baud_next = '0;
        if (rx_sync_reg) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign pop         = bus.rd_en && (count_reg != '0);
  assign full        = (count_reg == FULL_CNT);
  assign push_ok     = push && (!full || pop);
  assign overrun_set = push && full && !pop;

  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_wr_sel
      assign wr_sel[gi] = push_ok && (tail_reg == PTR_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_reg[i] <= '0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (wr_sel[i]) mem_reg[i] <= shift_reg;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (pop)     head_reg <= head_reg + 1'b1;
      if (push_ok) tail_reg <= tail_reg + 1'b1;
      count_reg <= count_next;
    end
  end

  // New error events take priority over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      frame_err_reg <= frame_set   | (frame_err_reg & ~bus.clr);
      overrun_reg   <= overrun_set | (overrun_reg   & ~bus.clr);
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) parity_err_reg <= 1'b0;
    else     parity_err_reg <= parity_set | (parity_err_reg & ~bus.clr);
  end
  assign bus.parity_err = parity_err_reg;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.rd_data    = mem_reg[head_reg];
  assign bus.data_valid = (count_reg != '0);
  assign bus.frame_err  = frame_err_reg;
  assign bus.overrun    = overrun_reg;
endmodule

// File: tb/tb_uart_rx_buf.sv
// Bench for uart_rx_buf: serial frames driven on rx, expected bytes queued in a scoreboard,
// a monitor pops and compares on every accepted read; flags checked against a frame-level model.
module tb_uart_rx_buf;
  localparam int CLOCK_HZ   = 6_400_000;
  localparam int BAUD_RATE  = 100_000;
  localparam int FIFO_DEPTH = 4;
  localparam int CPB        = CLOCK_HZ / BAUD_RATE;
  localparam int HALF       = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  // Pin edge to data_valid: synchroniser/edge detect (3) + stop sample point.
  localparam int LAT = 3 + HALF + (PAR_EN ? 10 : 9) * CPB;

  logic clk = 1'b0;
  logic rst;
  logic rx;

  uart_rx_buf_if bus_if ();

  uart_rx_buf #(
    .CLOCK_HZ  (CLOCK_HZ),
    .BAUD_RATE (BAUD_RATE),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx (rx),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_pops = 0;
  logic [7:0] exp_q [$];
  bit         exp_frame = 1'b0;
  bit         exp_overrun = 1'b0;
  bit         exp_parity = 1'b0;
  bit         reader_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_flags();
    check("frame_err", 32'(bus_if.frame_err), 32'(exp_frame));
    check("overrun", 32'(bus_if.overrun), 32'(exp_overrun));
    check("parity_err", 32'(bus_if.parity_err), 32'(exp_parity));
  endtask

  // Monitor: every cycle where the DUT will accept a read, compare the head against the scoreboard.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!rst && bus_if.rd_en && bus_if.data_valid) begin
        n_pops++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL pop_extra: got %02h expected no byte", bus_if.rd_data);
        end else begin
          e = exp_q.pop_front();
          $display("[%0t] pop %02h expect %02h", $time, bus_if.rd_data, e);
          check("rd_data", 32'(bus_if.rd_data), 32'(e));
        end
      end
    end
  end

  // Reader: random stalls while enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (reader_en) bus_if.rd_en = bus_if.data_valid && ($urandom_range(0, 3) != 0);
    end
  end

  task automatic set_reader(input bit en);
    @(posedge clk);
    #2;
    reader_en = en;
    if (!en) bus_if.rd_en = 1'b0;
  endtask

  task automatic pulse_pop();
    repeat (LAT - 1) @(posedge clk);
    #2 bus_if.rd_en = 1'b1;
    @(posedge clk);
    #2 bus_if.rd_en = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_bit, input bit par_flip,
                            input int hold_low, input bit pop_on_push);
    bit par_bad;
    par_bad = PAR_EN && par_flip;
    $display("[%0t] send %02h stop=%0b par_bad=%0b", $time, d, stop_bit, par_bad);
    @(posedge clk);
    if (pop_on_push) fork pulse_pop(); join_none
    #1 rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rx = d[i];
      repeat (CPB) @(posedge clk);
    end
    if (PAR_EN) begin
      #1 rx = (^d) ^ par_flip;
      repeat (CPB) @(posedge clk);
    end
    // Frame-level reference: decide the outcome before the DUT reaches its stop sample.
    if (par_bad) exp_parity = 1'b1;
    if (!stop_bit) exp_frame = 1'b1;
    else if (!par_bad) begin
      if (exp_q.size() >= FIFO_DEPTH && !pop_on_push) exp_overrun = 1'b1;
      else exp_q.push_back(d);
    end
    #1 rx = stop_bit;
    repeat (CPB) @(posedge clk);
    if (hold_low > 0) begin
      #1 rx = 1'b0;
      repeat (hold_low * CPB) @(posedge clk);
    end
    #1 rx = 1'b1;
    @(negedge clk);
    check_flags();
  endtask

  task automatic do_clr();
    @(posedge clk);
    #1 bus_if.clr = 1'b1;
    @(posedge clk);
    #1 bus_if.clr = 1'b0;
    exp_frame = 1'b0;
    exp_overrun = 1'b0;
    exp_parity = 1'b0;
    @(negedge clk);
    check_flags();
  endtask

  task automatic drain();
    int i;
    i = 0;
    set_reader(1'b1);
    while ((exp_q.size() != 0 || bus_if.data_valid) && i < 4000) begin
      @(negedge clk);
      i++;
    end
    repeat (4) @(negedge clk);
    check("drain_left", 32'(exp_q.size()), 32'd0);
    check("drain_valid", 32'(bus_if.data_valid), 32'd0);
  endtask

  task automatic measure_latency();
    int n;
    n = 0;
    @(posedge clk);
    while (n < 2 * LAT) begin
      @(posedge clk);
      #1 n++;
      if (bus_if.data_valid) break;
    end
    n_cmp++;
    if (n < LAT - 1 || n > LAT + 1) begin
      n_bad++;
      $display("FAIL latency: got %0d cycles required %0d +/-1", n, LAT);
    end else $display("[%0t] latency %0d cycles", $time, n);
  endtask

  task automatic check_reset_outputs();
    check("rst_rd_data", 32'(bus_if.rd_data), 32'h00);
    check("rst_data_valid", 32'(bus_if.data_valid), 32'd0);
    check("rst_frame_err", 32'(bus_if.frame_err), 32'd0);
    check("rst_overrun", 32'(bus_if.overrun), 32'd0);
    check("rst_parity_err", 32'(bus_if.parity_err), 32'd0);
  endtask

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: got no finish within 95000 cycles required completion");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic [7:0] aa_byte;
    bit         stop_bit;
    bit         pf;
    int         hold;
    int         snap;

    rst = 1'b1;
    rx = 1'b1;
    bus_if.rd_en = 1'b0;
    bus_if.clr = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2 * CPB) @(posedge clk);

    // First frame: latency from pin edge and fall-through head.
    fork
      send_frame(8'hAA, 1'b1, 1'b0, 0, 1'b0);
      measure_latency();
    join
    check("head_first", 32'(bus_if.rd_data), 32'(exp_q[0]));
    drain();

    // Short low pulse must be rejected in START.
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (CPB / 4) @(posedge clk);
    #1 rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("glitch_valid", 32'(bus_if.data_valid), 32'd0);
    check_flags();
    send_frame(8'h5A, 1'b1, 1'b0, 0, 1'b0);
    drain();

    // Five back-to-back frames with nobody reading: fifth overruns.
    set_reader(1'b0);
    for (int k = 0; k < 5; k++) send_frame(8'hAA, 1'b1, 1'b0, 0, 1'b0);
    check("ovr_valid", 32'(bus_if.data_valid), 32'd1);
    drain();
    do_clr();

    // Stop bit low followed by a held-low line, then a clean frame.
    send_frame(8'h81, 1'b0, 1'b0, 3, 1'b0);
    check("ferr_valid", 32'(bus_if.data_valid), 32'd0);
    do_clr();
    send_frame(8'h55, 1'b1, 1'b0, 0, 1'b0);
    drain();

    // Full FIFO with a read on the push cycle: no overrun, new byte ends up last.
    set_reader(1'b0);
    for (int k = 0; k < FIFO_DEPTH; k++) send_frame(8'($urandom), 1'b1, 1'b0, 0, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0, 0, 1'b1);
    snap = n_pops;
    drain();
    check("full_pop_count", 32'(n_pops - snap), 32'(FIFO_DEPTH));

    if (PAR_EN) begin
      send_frame(8'hAA, 1'b1, 1'b1, 0, 1'b0);
      check("par_valid", 32'(bus_if.data_valid), 32'd0);
      do_clr();
    end

    // Reset in the middle of DATA with bytes queued and a flag set.
    set_reader(1'b0);
    send_frame(8'h11, 1'b1, 1'b0, 0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 0, 1'b0);
    send_frame(8'h33, 1'b0, 1'b0, 0, 1'b0);
    aa_byte = 8'hAA;
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      #1 rx = aa_byte[i];
      repeat (CPB) @(posedge clk);
    end
    #1;
    rst = 1'b1;
    rx = 1'b1;
    exp_q.delete();
    exp_frame = 1'b0;
    exp_overrun = 1'b0;
    exp_parity = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    check("post_rst_valid", 32'(bus_if.data_valid), 32'd0);
    check_flags();
    set_reader(1'b1);
    send_frame(8'hAA, 1'b1, 1'b0, 0, 1'b0);
    drain();

    // Randomised traffic with occasional framing/parity faults.
    for (int k = 0; k < 24; k++) begin
      d = 8'($urandom);
      stop_bit = ($urandom_range(0, 7) != 0);
      pf = PAR_EN && ($urandom_range(0, 7) == 0);
      hold = stop_bit ? 0 : int'($urandom_range(0, 3));
      repeat ($urandom_range(0, CPB)) @(posedge clk);
      send_frame(d, stop_bit, pf, hold, 1'b0);
      if (exp_frame || exp_overrun || exp_parity) do_clr();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_buf.md
# uart_rx_buf

UART receive front end for the computer: samples the asynchronous `rx` pin, deserialises LSB-first 8N1 frames at BAUD_RATE, and queues received bytes in a small first-word-fall-through FIFO. The CPU's memory-mapped I/O read path drains the FIFO; sticky error flags report framing and overrun faults. It sits between the board `rx` pin and the CPU's I/O bus.

## Interface
- CLOCK_HZ, 50_000_000, system clock frequency
- BAUD_RATE, 115200, line rate; CLKS_PER_BIT = CLOCK_HZ / BAUD_RATE, integer floor (434 at defaults)
- FIFO_DEPTH, 4, byte entries; power of two, ≥2
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- rx  in  1  serial line, idle high, asynchronous to clk
- rd_en  in  1  pop head byte this cycle; ignored when empty
- clr  in  1  one-cycle pulse clears frame_err, overrun, parity_err
- rd_data  out  8  head byte (valid while data_valid = 1)
- data_valid  out  1  FIFO not empty
- frame_err  out  1  sticky: stop bit sampled low
- overrun  out  1  sticky: byte received while FIFO full
- parity_err  out  1  sticky: parity mismatch (see Configuration)

## Operation
- rx passes through a 2-flop synchroniser (reset to 1); all logic uses the synchronised value.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP, WAIT_IDLE. Bit counter 3 bits, baud counter ≥ $clog2(CLKS_PER_BIT) bits.
- IDLE: synchronised rx low → START, baud counter cleared.
- START: after CLKS_PER_BIT/2 cycles sample; low → DATA; high → IDLE (glitch rejected, nothing logged).
- DATA: sample every CLKS_PER_BIT cycles, shift into bit 7 of shift register (LSB first); after 8th sample → PARITY or STOP.
- STOP: sample after CLKS_PER_BIT; high → push byte, → IDLE; low → set frame_err, discard byte, → WAIT_IDLE.
- WAIT_IDLE: remain until synchronised rx high, → IDLE (prevents break condition re-triggering).
- FIFO: head/tail pointers wrap modulo FIFO_DEPTH; count 0..FIFO_DEPTH. Push accepted if count < FIFO_DEPTH or rd_en pops same cycle (count unchanged). Push when full without pop: byte dropped, overrun set, stored data untouched.
- rd_en while empty: no effect, pointers unchanged.
- clr concurrent with a new error event: event wins, flag stays set.

## Timing
- Reset: state IDLE, counters 0, FIFO empty, storage 0; rd_data = 8'h00, data_valid = 0, frame_err = overrun = parity_err = 0.
- Reset asserted mid-frame: frame aborted immediately, no partial byte pushed; after release, reception resumes on next falling edge only.
- Sample points relative to IDLE→START cycle: start at CLKS_PER_BIT/2, data bit n at CLKS_PER_BIT/2 + (n+1)·CLKS_PER_BIT, stop at CLKS_PER_BIT/2 + 9·CLKS_PER_BIT (4123 at defaults; +434 with parity).
- Push occurs on stop-sample cycle; data_valid and rd_data update the next cycle. Pin-to-data_valid latency: 4123 + 3 cycles (synchroniser + edge detect + register), ±1.
- rd_data is first-word-fall-through: head visible combinationally from storage; after pop, next byte visible the following cycle.
- Error flags assert the cycle after the detecting sample; clr takes effect the next cycle.

## Configuration
- UART_RX_PARITY_EN defined: frame is 8E1; PARITY state samples one bit after data at CLKS_PER_BIT; mismatch with even parity of data sets parity_err and the byte is discarded (STOP still checked, frame_err may also set).
- Undefined: 8N1, no PARITY state, parity_err tied to 0.

## Test plan
- Reset, idle rx=1 for 2 bit times, send 0xAA (8N1) → data_valid rises at 4126±1 cycles after start edge, rd_data = 8'hAA, no flags.
- Send 0xAA ×5 back-to-back without rd_en, FIFO_DEPTH 4 → data_valid = 1, four 0xAA readable in order, overrun = 1 after 5th stop bit; clr → overrun = 0.
- 1-bit-time-less glitch (rx low 100 cycles) → no state advance past START, data_valid stays 0.
- Frame with stop bit low then rx held low 3 bit times → frame_err = 1, FIFO empty, next valid 0x55 received correctly.
- FIFO full, rd_en asserted on push cycle of 0x3C → no overrun, count stays 4, 0x3C last out.
- Assert rst mid-DATA of 0xAA → all outputs reset values, FIFO empty; with UART_RX_PARITY_EN, 0xAA with parity 1 → parity_err = 1, byte dropped.
